bcd_seq_converter: RTL and testbench
====================================

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter IN_WIDTH, default 9, gives the binary input width; legal range 4..20.
REQ-002 Parameter DIGITS, default 3, gives the number of BCD output digits; legal range 1..6.
REQ-003 Parameter BLANK_EN, default 1, enables leading-zero blanking mask generation; when 0, blank is tied to all zeros.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to convert number; sampled on the rising edge.
REQ-007 number  input  IN_WIDTH  unsigned binary value; captured on an accepted start.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle pulse marking that the result outputs have updated.
REQ-010 digits  output  4*DIGITS  BCD result; digit k occupies bits [4k+3:4k], k=0 is the ones digit.
REQ-011 blank  output  DIGITS  bit k high means digit k is a leading zero.
REQ-012 overflow  output  1  high when the last captured number was >= 10^DIGITS.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE; busy is high only in SHIFT, and done is high only in DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; an accepted start captures number into a shift register, clears the BCD scratch register, loads the bit counter with IN_WIDTH, and moves the FSM to SHIFT.
REQ-015 start in SHIFT SHALL be ignored, with no queuing and no effect on the result.
REQ-016 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5 and then shift left by one bit (MSB of the shift register enters digit 0 bit 0), which is the double-dabble algorithm.
REQ-017 After exactly IN_WIDTH SHIFT cycles the FSM SHALL enter DONE for one cycle, registering digits, blank and overflow on that same edge.
REQ-018 done SHALL rise IN_WIDTH+1 rising edges after the accepting edge, which is 10 edges for the defaults.
REQ-019 DONE SHALL return to IDLE, or to SHIFT if start is high, which gives back-to-back conversions with a throughput of one per IN_WIDTH+1 cycles.
REQ-020 The scratch register SHALL hold enough digits for 2^IN_WIDTH-1; digits above DIGITS are used only for overflow detection.
REQ-021 When the captured value is >= 10^DIGITS, overflow SHALL be 1 and digits SHALL saturate to all 9s.
REQ-022 With BLANK_EN=1, blank bit k SHALL be 1 iff digit k and every digit above k are 0, for k >= 1; blank bit 0 SHALL always be 0.
REQ-023 When overflow is 1, blank SHALL be all zeros.
REQ-024 digits, blank and overflow SHALL hold their last value between done pulses and SHALL NOT change during SHIFT.
REQ-025 number may change freely after the accepting edge without affecting the conversion in flight.

Reset
REQ-026 reset_n low SHALL immediately force the FSM to IDLE, with busy=0, done=0, overflow=0, digits all zeros, and blank equal to {DIGITS-1 ones, 0}, or all zeros when BLANK_EN=0.
REQ-027 Reset asserted mid-conversion SHALL abort it with no done pulse; after release the first accepted start converts normally.
REQ-028 The first start SHALL be accepted on the first rising edge after reset_n is released.

Verification
REQ-029 Defaults, start with number=255 -> busy high for 9 cycles, done on edge 10, digits=2/5/5, blank=000, overflow=0.
REQ-030 Defaults, number=0 -> digits=0/0/0, blank=110, overflow=0; then number=7 -> digits=0/0/7, blank=110; then number=42 -> blank=100.
REQ-031 DIGITS=2, number=100 -> digits=9/9, overflow=1, blank=00; then number=99 -> digits=9/9, overflow=0.
REQ-032 Defaults, number=511 then start pulses during SHIFT with number=3 -> exactly one done, digits=5/1/1; start held in DONE with number=3 -> second done exactly 10 cycles later, digits=0/0/3.
REQ-033 Defaults, start with number=300, reset_n low on SHIFT cycle 4 -> outputs return to reset values at once, no done; after release start with number=128 -> digits=1/2/8 with correct latency.
REQ-034 IN_WIDTH=20, DIGITS=6, number=999999 -> digits all 9s, overflow=0, done on edge 21; number=1000000 -> overflow=1.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// Purpose : sequential binary-to-BCD converter (double dabble), one result bit per cycle,
//           with saturation to all 9s on overflow and an optional leading-zero blanking mask.
// Latency : busy for IN_WIDTH cycles after the accepting edge; done pulses in the next cycle.
// Backpr. : start is accepted only in IDLE or DONE; start during SHIFT is dropped (no queue).
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     conversion request, sampled on the rising edge
//   number    IN_WIDTH-bit unsigned value, captured on an accepted start
//   busy      high while shifting
//   done      one-cycle pulse, result outputs updated on the edge that raised it
//   digits    DIGITS packed BCD digits, digit 0 (ones) in bits [3:0]
//   blank     bit k set when digit k is a leading zero (bit 0 never set)
//   overflow  last captured value did not fit in DIGITS decimal digits
module bcd_seq_converter #(
    parameter int IN_WIDTH = 9,
    parameter int DIGITS   = 3,
    parameter int BLANK_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    // Decimal digit count of the largest input value 2^width - 1.
    function automatic int dec_digits_for(input int width);
        longint unsigned v;
        int              n;
        v = (longint'(1) << width) - 1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Blank mask for an all-zero result: every digit but the ones digit blanked.
    function automatic logic [DIGITS-1:0] blank_reset_val();
        logic [DIGITS-1:0] b;
        b = '0;
        if (BLANK_EN != 0) begin
            for (int k = 1; k < DIGITS; k++) begin
                b[k] = 1'b1;
            end
        end
        return b;
    endfunction

    // The scratch register must hold the full decimal value of any input so that
    // digits above DIGITS can flag overflow; it is never narrower than the output.
    localparam int NEED_DIGITS = dec_digits_for(IN_WIDTH);
    localparam int SCR_DIGITS  = (NEED_DIGITS > DIGITS) ? NEED_DIGITS : DIGITS;
    localparam int SW          = 4 * SCR_DIGITS;
    localparam int CW          = $clog2(IN_WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = blank_reset_val();

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic [IN_WIDTH-1:0]   shreg_q,    shreg_d;
    logic [SW-1:0]         scratch_q,  scratch_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [4*DIGITS-1:0]   digits_q,   digits_d;
    logic [DIGITS-1:0]     blank_q,    blank_d;
    logic                  overflow_q, overflow_d;

    logic [SW-1:0]         adj;
    logic [SW:0]           shifted;
    logic [4*DIGITS-1:0]   fin_digits;
    logic [DIGITS-1:0]     fin_blank;
    logic                  fin_overflow;
    logic                  upper_zero;

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // scratch left with the next input bit (MSB first) entering digit 0.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shreg_q[IN_WIDTH-1]};
    end

    // Result formatting from the value the last shift produces, so the
    // outputs register on the same edge that enters DONE.
    always_comb begin
        fin_digits   = '0;
        fin_blank    = '0;
        upper_zero   = 1'b1;
        // shifted[SW] cannot be set with a correctly sized scratch; folding it
        // in keeps a lost carry from ever reading as a valid result.
        fin_overflow = shifted[SW];
        for (int k = 0; k < SCR_DIGITS; k++) begin
            if ((k >= DIGITS) && (shifted[4*k +: 4] != 4'd0)) begin
                fin_overflow = 1'b1;
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            fin_digits[4*k +: 4] = fin_overflow ? 4'd9 : shifted[4*k +: 4];
        end
        // Walk down from the top digit; a digit is blank while everything
        // above it (and itself) is still zero. The ones digit is always shown.
        if ((BLANK_EN != 0) && !fin_overflow) begin
            for (int k = DIGITS - 1; k >= 1; k--) begin
                upper_zero   = upper_zero && (shifted[4*k +: 4] == 4'd0);
                fin_blank[k] = upper_zero;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = number;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_WIDTH);
                end
            end
            ST_SHIFT: begin
                shreg_d   = {shreg_q[IN_WIDTH-2:0], 1'b0};
                scratch_d = shifted[SW-1:0];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = ST_DONE;
                    digits_d   = fin_digits;
                    blank_d    = fin_blank;
                    overflow_d = fin_overflow;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            digits_q   <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Purpose : self-checking bench for bcd_seq_converter across four parameter sets.
// Latency : checks busy length and done position after each accepted start.
// Backpr. : exercises ignored starts during SHIFT and back-to-back starts from DONE.
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [19:0] num;
    int          sel;
    int          cur_w, cur_dig, cur_ben;

    int n_cmp = 0;
    int n_err = 0;

    logic start_a, start_b, start_c;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    logic        busy_a, done_a, ovf_a;
    logic [11:0] dig_a;
    logic [2:0]  blank_a;
    logic        nb_busy, nb_done, nb_ovf;
    logic [11:0] nb_dig;
    logic [2:0]  nb_blank;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  dig_b;
    logic [1:0]  blank_b;
    logic        busy_c, done_c, ovf_c;
    logic [23:0] dig_c;
    logic [5:0]  blank_c;

    bcd_seq_converter #(.IN_WIDTH(9), .DIGITS(3), .BLANK_EN(1)) u_def (
        .clk(clk), .reset_n(reset_n), .start(start_a), .number(num[8:0]),
        .busy(busy_a), .done(done_a), .digits(dig_a), .blank(blank_a), .overflow(ovf_a));

    bcd_seq_converter #(.IN_WIDTH(9), .DIGITS(3), .BLANK_EN(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .start(start_a), .number(num[8:0]),
        .busy(nb_busy), .done(nb_done), .digits(nb_dig), .blank(nb_blank), .overflow(nb_ovf));

    bcd_seq_converter #(.IN_WIDTH(9), .DIGITS(2), .BLANK_EN(1)) u_d2 (
        .clk(clk), .reset_n(reset_n), .start(start_b), .number(num[8:0]),
        .busy(busy_b), .done(done_b), .digits(dig_b), .blank(blank_b), .overflow(ovf_b));

    bcd_seq_converter #(.IN_WIDTH(20), .DIGITS(6), .BLANK_EN(1)) u_wide (
        .clk(clk), .reset_n(reset_n), .start(start_c), .number(num),
        .busy(busy_c), .done(done_c), .digits(dig_c), .blank(blank_c), .overflow(ovf_c));

    always #5 clk = ~clk;

    logic        obs_busy, obs_done, obs_ovf;
    logic [23:0] obs_digits;
    logic [5:0]  obs_blank;

    always_comb begin
        obs_busy   = busy_a;
        obs_done   = done_a;
        obs_ovf    = ovf_a;
        obs_digits = {12'b0, dig_a};
        obs_blank  = {3'b0, blank_a};
        case (sel)
            1: begin
                obs_busy   = busy_b;
                obs_done   = done_b;
                obs_ovf    = ovf_b;
                obs_digits = {16'b0, dig_b};
                obs_blank  = {4'b0, blank_b};
            end
            2: begin
                obs_busy   = busy_c;
                obs_done   = done_c;
                obs_ovf    = ovf_c;
                obs_digits = dig_c;
                obs_blank  = blank_c;
            end
            default: ;
        endcase
    end

    // Last result each instance should be holding.
    logic [23:0] prev_d [3];
    logic [5:0]  prev_b [3];
    logic        prev_o [3];

    // Reference: decimal digits by repeated division, saturation by comparing
    // against 10^nd, blanking as "value below 10^k".
    function automatic void ref_model(input longint v, input int nd, input int ben,
                                      output logic [23:0] d, output logic [5:0] b,
                                      output logic o);
        longint lim;
        longint t;
        longint p;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        o = (v >= lim);
        d = '0;
        b = '0;
        t = v;
        for (int k = 0; k < nd; k++) begin
            d[4*k +: 4] = o ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
        p = 1;
        for (int k = 1; k < nd; k++) begin
            p = p * 10;
            b[k] = (ben != 0) && !o && (v < p);
        end
    endfunction

    function automatic logic [5:0] reset_blank(input int nd, input int ben);
        logic [5:0] b;
        b = '0;
        if (ben != 0) b = 6'((1 << nd) - 2);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic use_dut(input int s);
        sel = s;
        case (s)
            1:       begin cur_w = 9;  cur_dig = 2; cur_ben = 1; end
            2:       begin cur_w = 20; cur_dig = 6; cur_ben = 1; end
            default: begin cur_w = 9;  cur_dig = 3; cur_ben = 1; end
        endcase
    endtask

    task automatic reset_prev();
        prev_d[0] = '0; prev_b[0] = reset_blank(3, 1); prev_o[0] = 1'b0;
        prev_d[1] = '0; prev_b[1] = reset_blank(2, 1); prev_o[1] = 1'b0;
        prev_d[2] = '0; prev_b[2] = reset_blank(6, 1); prev_o[2] = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        int keep;
        keep = sel;
        for (int s = 0; s < 3; s++) begin
            use_dut(s);
            #1;
            chk({tag, "_busy"},   obs_busy,   0);
            chk({tag, "_done"},   obs_done,   0);
            chk({tag, "_ovf"},    obs_ovf,    0);
            chk({tag, "_digits"}, obs_digits, 0);
            chk({tag, "_blank"},  obs_blank,  reset_blank(cur_dig, cur_ben));
        end
        chk({tag, "_nb_blank"}, nb_blank, 0);
        chk({tag, "_nb_busy"},  nb_busy,  0);
        use_dut(keep);
    endtask

    // Called at a falling edge: present a start, let one rising edge accept it,
    // then scramble number while the conversion is in flight.
    task automatic issue(input logic [19:0] v);
        num   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        num   = 20'($urandom);
    endtask

    // Entered at the falling edge after the accepting edge (cycle 1).
    task automatic finish_check(input logic [19:0] v, input bit noise);
        int          n;
        int          busy_n;
        logic [23:0] ed;
        logic [5:0]  eb;
        logic        eo;
        n      = 1;
        busy_n = 0;
        while (obs_done !== 1'b1 && n < 40) begin
            if (obs_busy === 1'b1) busy_n++;
            chk("hold_digits", obs_digits, prev_d[sel]);
            chk("hold_blank",  obs_blank,  prev_b[sel]);
            chk("hold_ovf",    obs_ovf,    prev_o[sel]);
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                num   = 20'd3;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_latency", n,      cur_w + 1);
        chk("busy_cycles",  busy_n, cur_w);
        chk("busy_in_done", obs_busy, 0);
        ref_model(longint'(v), cur_dig, cur_ben, ed, eb, eo);
        chk("digits",   obs_digits, ed);
        chk("blank",    obs_blank,  eb);
        chk("overflow", obs_ovf,    eo);
        if (sel == 0) begin
            ref_model(longint'(v), 3, 0, ed, eb, eo);
            chk("nb_done",   nb_done,  1);
            chk("nb_digits", nb_dig,   ed[11:0]);
            chk("nb_blank",  nb_blank, 0);
            chk("nb_ovf",    nb_ovf,   eo);
            ref_model(longint'(v), cur_dig, cur_ben, ed, eb, eo);
        end
        prev_d[sel] = ed;
        prev_b[sel] = eb;
        prev_o[sel] = eo;
    endtask

    task automatic settle();
        @(negedge clk);
        chk("done_single", obs_done,   0);
        chk("idle_busy",   obs_busy,   0);
        chk("idle_digits", obs_digits, prev_d[sel]);
    endtask

    task automatic convert(input logic [19:0] v);
        issue(v);
        finish_check(v, 1'b0);
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v;
        start   = 1'b0;
        num     = '0;
        use_dut(0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        reset_prev();
        @(negedge clk);
        check_reset("por");
        @(negedge clk);
        reset_n = 1'b1;

        // First start on the first edge after release.
        issue(20'd255);
        finish_check(20'd255, 1'b0);
        chk("v255_digits", obs_digits, 24'h255);
        chk("v255_blank",  obs_blank,  0);
        settle();

        convert(20'd0);
        chk("v0_blank", obs_blank, 6'b110);
        convert(20'd7);
        chk("v7_digits", obs_digits, 24'h007);
        convert(20'd42);
        chk("v42_blank", obs_blank, 6'b100);

        // Starts during SHIFT are ignored; a start held in DONE chains directly.
        issue(20'd511);
        finish_check(20'd511, 1'b1);
        chk("v511_digits", obs_digits, 24'h511);
        issue(20'd3);
        finish_check(20'd3, 1'b0);
        chk("v3_digits", obs_digits, 24'h003);
        settle();

        for (int i = 0; i < 8; i++) begin
            v = 20'($urandom_range(0, 511));
            convert(v);
        end

        // Reset in the middle of a conversion.
        issue(20'd300);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        reset_prev();
        check_reset("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", obs_done, 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(20'd128);
        finish_check(20'd128, 1'b0);
        chk("v128_digits", obs_digits, 24'h128);
        settle();

        use_dut(1);
        convert(20'd100);
        chk("d2_v100_ovf",    obs_ovf,    1);
        chk("d2_v100_digits", obs_digits, 24'h99);
        convert(20'd99);
        chk("d2_v99_ovf", obs_ovf, 0);
        for (int i = 0; i < 5; i++) begin
            v = 20'($urandom_range(0, 511));
            convert(v);
        end

        use_dut(2);
        convert(20'd999999);
        chk("w_999999_digits", obs_digits, 24'h999999);
        chk("w_999999_ovf",    obs_ovf,    0);
        convert(20'd1000000);
        chk("w_1000000_ovf", obs_ovf, 1);
        convert(20'hFFFFF);
        for (int i = 0; i < 4; i++) begin
            v = 20'($urandom_range(0, 20'hFFFFF));
            convert(v);
            v = 20'($urandom_range(999000, 1001000));
            convert(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
